// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave stream block.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RX
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus a history flop for edge detection.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RESET_VAL}};
      hist <= RESET_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave receiver (CPHA=0, MSB first) that delivers bytes on a valid/ready stream
// with one pending byte of look-ahead so the last byte of a frame can be flagged.
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic CPOL        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic [SPI_BYTE_W-1:0] spi_rdata,
  output logic                  spi_rvalid,
  input  logic                  spi_rready,
  output logic                  spi_rlast,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int          STAGES   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [3:0] BIT_LAST = 4'(SPI_BYTE_W - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic cs_lvl, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  spi_sync_edge #(.STAGES(STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_n),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall, cs_lvl};

  // Blanks the cs_n fall that appears when reset releases mid-frame and the preset
  // synchronizer value drains out.
  logic [STAGES+1:0] warm;
  logic              ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) warm <= '0;
    else        warm <= {warm[STAGES:0], 1'b1};
  end
  assign ready = warm[STAGES+1];

  logic                  sample;
  spi_state_e            state;
  logic [3:0]            bit_cnt;
  logic [SPI_BYTE_W-1:0] shift_reg;
  logic [SPI_BYTE_W-1:0] pend_data;
  logic                  pend_v;
  logic [SPI_BYTE_W-1:0] byte_next;
  logic                  push_req;
  logic                  push_last;

  assign sample    = CPOL ? sclk_fall : sclk_rise;
  assign byte_next = {shift_reg[SPI_BYTE_W-2:0], mosi_lvl};

  always_comb begin
    push_req  = 1'b0;
    push_last = 1'b0;
    if (state == ST_RX) begin
      if (cs_rise) begin
        push_req  = pend_v;
        push_last = 1'b1;
      end else if (sample && bit_cnt == BIT_LAST) begin
        push_req = pend_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      pend_data  <= '0;
      pend_v     <= 1'b0;
      spi_rdata  <= '0;
      spi_rvalid <= 1'b0;
      spi_rlast  <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      if (spi_rvalid && spi_rready) spi_rvalid <= 1'b0;

      // Output slot is free or being drained this cycle; otherwise the older byte is lost.
      if (push_req) begin
        if (!spi_rvalid || spi_rready) begin
          spi_rdata  <= pend_data;
          spi_rlast  <= push_last;
          spi_rvalid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (cs_fall && ready) begin
            state     <= ST_RX;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end
        ST_RX: begin
          if (cs_rise) begin
            pend_v    <= 1'b0;
            frame_err <= (bit_cnt != 4'd0);
            state     <= ST_IDLE;
          end else if (sample) begin
            shift_reg <= byte_next;
            if (bit_cnt == BIT_LAST) begin
              pend_data <= byte_next;
              pend_v    <= 1'b1;
              bit_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_stream.sv
// Randomized self-checking bench for spi_slave_stream against a frame-level reference model.
module tb_spi_slave_stream;

  localparam int   SYNC_STAGES = 2;
  localparam logic CPOL        = 1'b0;
  localparam int   HALF        = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = CPOL;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       spi_rready = 1'b0;
  logic [7:0] spi_rdata;
  logic       spi_rvalid;
  logic       spi_rlast;
  logic       overrun;
  logic       frame_err;

  always #5 clk = ~clk;

  spi_slave_stream #(.SYNC_STAGES(SYNC_STAGES), .CPOL(CPOL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .spi_rdata  (spi_rdata),
    .spi_rvalid (spi_rvalid),
    .spi_rready (spi_rready),
    .spi_rlast  (spi_rlast),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] beats[$];
  int         n_ovr = 0;
  int         n_ferr = 0;

  // Observed stream: {rlast, rdata} per accepted beat, plus error pulse counts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (spi_rvalid && spi_rready) beats.push_back({spi_rlast, spi_rdata});
      if (overrun) n_ovr++;
      if (frame_err) n_ferr++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    beats.delete();
    n_ovr  = 0;
    n_ferr = 0;
  endtask

  task automatic send_bits(input int nbits, input logic [63:0] bits);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = bits[i];
      wait_clks(HALF);
      sclk = ~CPOL;
      wait_clks(HALF);
      sclk = CPOL;
    end
  endtask

  task automatic spi_frame(input int nbits, input logic [63:0] bits);
    cs_n = 1'b0;
    wait_clks(HALF);
    send_bits(nbits, bits);
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(16);
  endtask

  function automatic logic [7:0] byte_at(input int nbits, input logic [63:0] bits, input int k);
    logic [63:0] t;
    t = bits >> (nbits - 8 * (k + 1));
    return t[7:0];
  endfunction

  // Consumer always ready: every complete byte appears, last one flagged.
  task automatic run_streaming(input string tag, input int nbits, input logic [63:0] bits);
    int nb;
    nb = nbits / 8;
    spi_rready = 1'b1;
    clear_mon();
    spi_frame(nbits, bits);
    check_val({tag, " beats"}, beats.size(), nb);
    for (int k = 0; k < nb && k < beats.size(); k++)
      check_val({tag, " beat"}, {23'd0, beats[k]}, {23'd0, (k == nb - 1), byte_at(nbits, bits, k)});
    check_val({tag, " overrun"}, n_ovr, 0);
    check_val({tag, " frame_err"}, n_ferr, (nbits % 8 != 0) ? 1 : 0);
  endtask

  // Consumer stalled for the whole frame: only the first byte survives.
  task automatic run_backpressure(input string tag, input int nbits, input logic [63:0] bits);
    int nb;
    nb = nbits / 8;
    spi_rready = 1'b1;
    wait_clks(4);
    spi_rready = 1'b0;
    clear_mon();
    spi_frame(nbits, bits);
    check_val({tag, " held_valid"}, spi_rvalid, (nb > 0) ? 1 : 0);
    if (nb > 0) begin
      check_val({tag, " held_data"}, spi_rdata, byte_at(nbits, bits, 0));
      check_val({tag, " held_last"}, spi_rlast, (nb == 1) ? 1 : 0);
    end
    check_val({tag, " overrun"}, n_ovr, (nb > 0) ? nb - 1 : 0);
    check_val({tag, " frame_err"}, n_ferr, (nbits % 8 != 0) ? 1 : 0);
    spi_rready = 1'b1;
    wait_clks(4);
    check_val({tag, " drain_beats"}, beats.size(), (nb > 0) ? 1 : 0);
    if (nb > 0 && beats.size() > 0)
      check_val({tag, " drain_beat"}, {23'd0, beats[0]},
                {23'd0, (nb == 1), byte_at(nbits, bits, 0)});
    check_val({tag, " drained"}, spi_rvalid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " rvalid"}, spi_rvalid, 0);
    check_val({tag, " rdata"}, spi_rdata, 0);
    check_val({tag, " rlast"}, spi_rlast, 0);
    check_val({tag, " overrun"}, overrun, 0);
    check_val({tag, " frame_err"}, frame_err, 0);
  endtask

  initial begin
    int nbits;
    int nb;
    logic [63:0] bits;

    wait_clks(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_clks(6);

    run_streaming("single_a5", 8, 64'hA5);
    run_streaming("multi_010203", 24, 64'h010203);
    run_backpressure("bp_112233", 24, 64'h112233);
    run_streaming("partial_c3f", 12, 64'hC3F);
    run_streaming("empty", 0, 64'h0);

    // Leave a stalled byte in the output, then reset in the middle of the next frame.
    spi_rready = 1'b0;
    spi_frame(8, 64'h5A);
    cs_n = 1'b0;
    wait_clks(HALF);
    send_bits(4, 64'hA);
    rst_n = 1'b0;
    wait_clks(3);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    clear_mon();
    spi_rready = 1'b1;
    send_bits(8, 64'hFF);
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(16);
    check_val("midrst beats", beats.size(), 0);
    check_val("midrst frame_err", n_ferr, 0);
    check_val("midrst overrun", n_ovr, 0);
    run_streaming("post_rst", 8, 64'h3C);

    for (int i = 0; i < 16; i++) begin
      nbits = $urandom_range(0, 40);
      bits  = {$urandom, $urandom};
      run_streaming("rand_stream", nbits, bits);
    end

    for (int i = 0; i < 6; i++) begin
      nb    = $urandom_range(0, 4);
      nbits = 8 * nb + $urandom_range(0, 7);
      bits  = {$urandom, $urandom};
      run_backpressure("rand_bp", nbits, bits);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_stream.md
SPI_SLAVE_STREAM -- requirements
Module: spi_slave_stream

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for sclk, mosi and cs_n (minimum 2).
REQ-002 SHALL have parameter CPOL, default 1'b0, meaning the SCLK idle level; the sampling edge is the CPOL->~CPOL transition; only CPHA=0, MSB-first is supported.
REQ-003 SHALL have port clk, input, 1, system clock; the block uses one clock only.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port sclk, input, 1, SPI serial clock, asynchronous to clk.
REQ-006 SHALL have port mosi, input, 1, SPI data, asynchronous to clk.
REQ-007 SHALL have port cs_n, input, 1, SPI chip select, active-low, asynchronous to clk.
REQ-008 SHALL have port spi_rdata, output, 8, received byte.
REQ-009 SHALL have port spi_rvalid, output, 1, spi_rdata and spi_rlast are valid.
REQ-010 SHALL have port spi_rready, input, 1, consumer accepts the byte.
REQ-011 SHALL have port spi_rlast, output, 1, the byte is the last of its cs_n frame.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse when a byte is dropped.
REQ-013 SHALL have port frame_err, output, 1, one-cycle pulse when cs_n deasserts mid-byte.

Function
REQ-014 SHALL pass sclk, mosi and cs_n through SYNC_STAGES flops each, plus one history flop per signal for edge detection.
REQ-015 SHALL run a state machine with states ST_IDLE and ST_RX.
REQ-016 SHALL move ST_IDLE->ST_RX on a synced cs_n falling edge, clearing the bit counter (4 bits, 0..8) and the shift register.
REQ-017 SHALL, in ST_RX on a synced sampling edge, shift the synced mosi into the LSB (shift left) and increment the bit counter.
REQ-018 SHALL, when the counter reaches 8, move the byte into a one-entry pending register (pend_v=1) and clear the counter in the same cycle.
REQ-019 SHALL, if pend_v is already 1 when a new byte completes, push the old pending byte to the output with rlast=0 in that cycle.
REQ-020 SHALL, on a synced cs_n rising edge in ST_RX, push the pending byte (if pend_v) with rlast=1, clear pend_v, and return to ST_IDLE.
REQ-021 SHALL, if the counter is nonzero at the cs_n rise, discard the partial byte and pulse frame_err for one cycle.
REQ-022 SHALL, for a frame with zero complete bytes, produce no output; frame_err follows REQ-021.
REQ-023 SHALL hold the output register stable while spi_rvalid=1 and spi_rready=0; the transfer completes on the cycle where spi_rvalid and spi_rready are both 1.
REQ-024 SHALL accept a push when spi_rvalid=0, or when spi_rvalid=1 and spi_rready=1 in the same cycle (back-to-back, no bubble).
REQ-025 SHALL, when a push is required but the output is full and not being accepted, drop the pushed (older) byte, keep the output unchanged, and pulse overrun.
REQ-026 SHALL present spi_rvalid 1 clk after the internal push cycle (registered output).
REQ-027 SHALL ignore sampling edges while in ST_IDLE.
REQ-028 SHALL require an SCLK half-period of at least SYNC_STAGES+2 clk cycles; faster SCLK is out of scope.

Reset
REQ-029 SHALL, while rst_n=0, force state=ST_IDLE, counter=0, shift=8'h00, pend_v=0, spi_rdata=8'h00, spi_rvalid=0, spi_rlast=0, overrun=0, frame_err=0.
REQ-030 SHALL preset the synchronizer and history flops to cs_n=1, sclk=CPOL and mosi=0, so that no false edge is detected after reset.
REQ-031 SHALL wait for the first cs_n falling edge seen after reset release when reset deasserts mid-frame (cs_n already low); no bytes are produced from that partial frame.

Structure
REQ-032 SHALL define the state enum (ST_IDLE, ST_RX) in the shared package spi_pkg, together with the SPI_BYTE_W=8 constant.
REQ-033 SHALL implement the synchronizer and edge detect as the sub-module spi_sync_edge (parameter STAGES; outputs level, rise, fall), instantiated three times.

Verification
REQ-034 SHALL cover a single-byte frame: frame 8'hA5, rready=1 -> one beat with rdata=A5, rlast=1, no error pulses.
REQ-035 SHALL cover a multi-byte frame: frame {8'h01, 8'h02, 8'h03} -> three beats, rlast=0,0,1, in order.
REQ-036 SHALL cover backpressure: frame {8'h11, 8'h22, 8'h33} with rready=0 throughout -> output holds 11, overrun pulses twice, and rready rising then yields 11 only.
REQ-037 SHALL cover a partial byte: 12 bits 8'hC3 then 4'hF, then cs_n high -> beat C3 with rlast=1 and one frame_err pulse.
REQ-038 SHALL cover an empty frame: cs_n low then high with no sclk -> no beats and no pulses.
REQ-039 SHALL cover reset mid-frame: rst_n asserted after 4 bits, released with cs_n low -> all outputs at reset values and no beats until the next cs_n falling edge.
